// File: rtl/fb_pixel_writer.sv
// Write-side engine for the 4-bit palette-index framebuffer: single-pixel writes over
// valid/ready plus a full-screen clear sweep, driving the RAM write port from registers.
module fb_pixel_writer #(
    parameter int unsigned H_RES  = 800,
    parameter int unsigned V_RES  = 480,
    parameter int unsigned PACKED = 0,
    parameter int unsigned ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              px_valid,
    output logic              px_ready,
    input  logic [9:0]        px_x,
    input  logic [9:0]        px_y,
    input  logic [3:0]        px_index,
    input  logic              clear_start,
    input  logic [3:0]        clear_index,
    output logic              busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_din,
    output logic [1:0]        ram_we
);

    localparam int unsigned DEPTH = (PACKED != 0) ? (H_RES * V_RES) / 2 : H_RES * V_RES;
    localparam int unsigned LW    = ADDR_W + 1;

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [LW-1:0]     lin;
    logic              in_range;
    logic              accept;
    logic [1:0]        fill_we;

    always_comb begin
        lin      = LW'(px_y) * LW'(H_RES) + LW'(px_x);
        in_range = (32'(px_x) < H_RES) && (32'(px_y) < V_RES);
        fill_we  = (PACKED != 0) ? 2'b11 : 2'b01;
    end

    // Clear has priority over a pixel presented in the same cycle.
    assign px_ready = (state == StIdle) && !clear_start;
    assign accept   = px_valid && px_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            cnt        <= '0;
            ram_addr   <= '0;
            ram_din    <= '0;
            ram_we     <= 2'b00;
            busy       <= 1'b0;
            clear_done <= 1'b0;
        end else begin
            ram_we     <= 2'b00;
            clear_done <= 1'b0;
            case (state)
                StIdle: begin
                    if (clear_start) begin
                        state    <= StClear;
                        cnt      <= '0;
                        ram_addr <= '0;
                        ram_din  <= {clear_index, clear_index};
                        ram_we   <= fill_we;
                        busy     <= 1'b1;
                    end else if (accept && in_range) begin
                        if (PACKED != 0) begin
                            ram_addr <= lin[ADDR_W:1];
                            ram_din  <= {px_index, px_index};
                            ram_we   <= lin[0] ? 2'b10 : 2'b01;
                        end else begin
                            ram_addr <= lin[ADDR_W-1:0];
                            ram_din  <= {4'b0000, px_index};
                            ram_we   <= 2'b01;
                        end
                    end
                end
                StClear: begin
                    // cnt is the address currently on the port; ram_din still holds the fill.
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state      <= StDone;
                        busy       <= 1'b0;
                        clear_done <= 1'b1;
                    end else begin
                        cnt      <= cnt + 1'b1;
                        ram_addr <= cnt + 1'b1;
                        ram_we   <= fill_we;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench: an unpacked (dut0) and a packed (dut1) 8x4 writer driven with table
// vectors, then hand-written clear, clear-vs-pixel and mid-sweep reset sequences.
module tb_fb_pixel_writer;

    logic        clk;
    logic        rst;
    logic        valid0, valid1, cs0, cs1;
    logic [9:0]  x, y;
    logic [3:0]  idx, ci;
    logic        ready0, ready1, busy0, busy1, done0, done1;
    logic [18:0] addr0, addr1;
    logic [7:0]  din0, din1;
    logic [1:0]  we0, we1;

    int passed = 0;
    int total  = 0;

    fb_pixel_writer #(.H_RES(8), .V_RES(4), .PACKED(0), .ADDR_W(19)) dut0 (
        .clk(clk), .rst(rst), .px_valid(valid0), .px_ready(ready0), .px_x(x), .px_y(y),
        .px_index(idx), .clear_start(cs0), .clear_index(ci), .busy(busy0),
        .clear_done(done0), .ram_addr(addr0), .ram_din(din0), .ram_we(we0)
    );

    fb_pixel_writer #(.H_RES(8), .V_RES(4), .PACKED(1), .ADDR_W(19)) dut1 (
        .clk(clk), .rst(rst), .px_valid(valid1), .px_ready(ready1), .px_x(x), .px_y(y),
        .px_index(idx), .clear_start(cs1), .clear_index(ci), .busy(busy1),
        .clear_done(done1), .ram_addr(addr1), .ram_din(din1), .ram_we(we1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        valid;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  idx;
        logic [18:0] a0;
        logic [7:0]  d0;
        logic [1:0]  w0;
        logic [18:0] a1;
        logic [7:0]  d1;
        logic [1:0]  w1;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; valid0 = 0; valid1 = 0; cs0 = 0; cs1 = 0;
        x = '0; y = '0; idx = '0; ci = '0;

        vecs[0] = '{1'b1, 10'd3, 10'd2, 4'd5,  19'd19, 8'h05, 2'b01, 19'd9,  8'h55, 2'b10};
        vecs[1] = '{1'b0, 10'd0, 10'd0, 4'd0,  19'd0,  8'h00, 2'b00, 19'd0,  8'h00, 2'b00};
        vecs[2] = '{1'b1, 10'd2, 10'd0, 4'd7,  19'd2,  8'h07, 2'b01, 19'd1,  8'h77, 2'b01};
        vecs[3] = '{1'b1, 10'd3, 10'd0, 4'd9,  19'd3,  8'h09, 2'b01, 19'd1,  8'h99, 2'b10};
        vecs[4] = '{1'b1, 10'd8, 10'd0, 4'd3,  19'd0,  8'h00, 2'b00, 19'd0,  8'h00, 2'b00};
        vecs[5] = '{1'b1, 10'd0, 10'd4, 4'd3,  19'd0,  8'h00, 2'b00, 19'd0,  8'h00, 2'b00};
        vecs[6] = '{1'b1, 10'd7, 10'd3, 4'd15, 19'd31, 8'h0F, 2'b01, 19'd15, 8'hFF, 2'b10};
        vecs[7] = '{1'b1, 10'd0, 10'd0, 4'd1,  19'd0,  8'h01, 2'b01, 19'd0,  8'h11, 2'b01};
        vecs[8] = '{1'b0, 10'd0, 10'd0, 4'd0,  19'd0,  8'h00, 2'b00, 19'd0,  8'h00, 2'b00};

        // Reset state
        #12;
        chk("rst_we0", 32'(we0), 0);     chk("rst_addr0", 32'(addr0), 0);
        chk("rst_din0", 32'(din0), 0);   chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0); chk("rst_we1", 32'(we1), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready1", 32'(ready1), 1);

        // Pixel vectors, one per cycle
        for (int i = 0; i < 9; i++) begin
            valid0 = vecs[i].valid; valid1 = vecs[i].valid;
            x = vecs[i].x; y = vecs[i].y; idx = vecs[i].idx;
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(ready0), 1);
            chk($sformatf("v%0d_ready1", i), 32'(ready1), 1);
            tick();
            chk($sformatf("v%0d_we0", i), 32'(we0), 32'(vecs[i].w0));
            chk($sformatf("v%0d_we1", i), 32'(we1), 32'(vecs[i].w1));
            if (vecs[i].w0 != 2'b00) begin
                chk($sformatf("v%0d_addr0", i), 32'(addr0), 32'(vecs[i].a0));
                chk($sformatf("v%0d_din0", i), 32'(din0), 32'(vecs[i].d0));
            end
            if (vecs[i].w1 != 2'b00) begin
                chk($sformatf("v%0d_addr1", i), 32'(addr1), 32'(vecs[i].a1));
                chk($sformatf("v%0d_din1", i), 32'(din1), 32'(vecs[i].d1));
            end
        end

        // Packed clear with a same-cycle pixel request that must wait for clear_done
        cs1 = 1'b1; ci = 4'hA; valid1 = 1'b1; x = 10'd1; y = 10'd0; idx = 4'd4;
        #1;
        chk("clr_ready_at_start", 32'(ready1), 0);
        tick();
        cs1 = 1'b0; ci = 4'h5;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("clr%0d_busy", k), 32'(busy1), 1);
            chk($sformatf("clr%0d_we", k), 32'(we1), 32'h3);
            chk($sformatf("clr%0d_addr", k), 32'(addr1), k);
            chk($sformatf("clr%0d_din", k), 32'(din1), 32'hAA);
            chk($sformatf("clr%0d_ready", k), 32'(ready1), 0);
            chk($sformatf("clr%0d_done", k), 32'(done1), 0);
            if (k == 3) cs1 = 1'b1;   // ignored while busy
            if (k == 4) cs1 = 1'b0;
            tick();
        end
        chk("clr_done_pulse", 32'(done1), 1);
        chk("clr_done_busy", 32'(busy1), 0);
        chk("clr_done_we", 32'(we1), 0);
        chk("clr_done_ready", 32'(ready1), 0);
        tick();
        chk("clr_after_done", 32'(done1), 0);
        chk("clr_after_ready", 32'(ready1), 1);
        tick();
        chk("late_px_we", 32'(we1), 32'h2);
        chk("late_px_addr", 32'(addr1), 0);
        chk("late_px_din", 32'(din1), 32'h44);
        chk("dut0_idle_we", 32'(we0), 0);
        valid1 = 1'b0;
        tick();
        chk("late_px_one_cycle", 32'(we1), 0);

        // Reset in the middle of a sweep
        cs0 = 1'b1; cs1 = 1'b1; ci = 4'h3;
        tick();
        cs0 = 1'b0; cs1 = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_addr0", 32'(addr0), 5);
        chk("mid_addr1", 32'(addr1), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_we0", 32'(we0), 0);   chk("mid_rst_addr0", 32'(addr0), 0);
        chk("mid_rst_din0", 32'(din0), 0); chk("mid_rst_busy0", 32'(busy0), 0);
        chk("mid_rst_we1", 32'(we1), 0);   chk("mid_rst_busy1", 32'(busy1), 0);
        tick();
        rst = 1'b0;
        valid0 = 1'b1; valid1 = 1'b1; x = 10'd2; y = 10'd1; idx = 4'd6;
        #1;
        chk("post_rst_ready0", 32'(ready0), 1);
        chk("post_rst_ready1", 32'(ready1), 1);
        tick();
        valid0 = 1'b0; valid1 = 1'b0;
        chk("post_rst_we0", 32'(we0), 1);
        chk("post_rst_addr0", 32'(addr0), 10);
        chk("post_rst_din0", 32'(din0), 32'h06);
        chk("post_rst_we1", 32'(we1), 1);
        chk("post_rst_addr1", 32'(addr1), 5);
        chk("post_rst_din1", 32'(din1), 32'h66);
        begin
            int stray = 0;
            for (int k = 0; k < 40; k++) begin
                if (done0 || done1 || busy0 || busy1) stray++;
                tick();
            end
            chk("no_done_after_abort", 32'(stray), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
